// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_ctrl_pkg;

    // Default operand / result width of the engine.
    localparam int DATA_WIDTH = 32;

    // Controller states. DONE doubles as an accept state so that
    // back-to-back operations need no idle bubble.
    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// START/BUSY/DONE handshake bundle between control unit and serial adder.
// Latency: n/a (wires only).
// Backpressure: requester must hold START until it sees it accepted (BUSY next cycle).
interface serial_adder_ctrl_if #(
    parameter int WIDTH = serial_adder_ctrl_pkg::DATA_WIDTH
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] RESULT;
    logic             CO;
    logic             OVF;
    logic             BUSY;
    logic             DONE;

    // Control-unit side: issues requests, consumes results.
    modport master (
        output START, SUB, A, B,
        input  RESULT, CO, OVF, BUSY, DONE
    );

    // Adder side: consumes requests, produces results.
    modport slave (
        input  START, SUB, A, B,
        output RESULT, CO, OVF, BUSY, DONE
    );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Half-adder cell used twice to build the shared one-bit full adder.
// Latency: purely combinational.
// Backpressure: none.
module serial_adder_ctrl_half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    // One-bit sum and carry of two inputs.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end
endmodule

// One-bit full adder: two half adders plus an OR, shared by every bit position.
// Latency: purely combinational.
// Backpressure: none.
module serial_adder_ctrl_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    serial_adder_ctrl_half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    serial_adder_ctrl_half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (sum),
        .c (c2)
    );

    // The two partial carries can never both be set, so OR gives the majority.
    always_comb begin
        cout = c1 | c2;
    end
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one shared full-adder cell stepped LSB-first over the word.
// Latency: WIDTH+1 cycles from the accepting edge to the one-cycle DONE pulse.
// Backpressure: START is only accepted in IDLE or DONE; START while BUSY is ignored.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    serial_adder_ctrl_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Bit index of the MSB and of the bit just below it, in counter width.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

    sa_state_e        state_q, state_d;

    logic [WIDTH-1:0] a_sh_q,     a_sh_d;
    logic [WIDTH-1:0] b_sh_q,     b_sh_d;
    logic [WIDTH-1:0] res_sh_q,   res_sh_d;
    logic             carry_q,    carry_d;
    logic             c_msb_in_q, c_msb_in_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [WIDTH-1:0] result_q,   result_d;
    logic             co_q,       co_d;
    logic             ovf_q,      ovf_d;

    logic             accept;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;

    // The single shared adder cell always looks at the current LSBs and carry.
    serial_adder_ctrl_full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // A request is taken whenever the engine is not mid-operation.
    always_comb begin
        accept = bus.START && ((state_q == SA_IDLE) || (state_q == SA_DONE));
    end

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: DONE lasts one cycle and may chain straight into RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SA_IDLE: begin
                if (bus.START) begin
                    state_d = SA_RUN;
                end
            end
            SA_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SA_DONE;
                end
            end
            SA_DONE: begin
                state_d = bus.START ? SA_RUN : SA_IDLE;
            end
            default: begin
                state_d = SA_IDLE;
            end
        endcase
    end

    // FSM outputs are decoded from the state flop only, never from inputs.
    always_comb begin
        busy = (state_q == SA_RUN);
        done = (state_q == SA_DONE);
    end

    // Datapath next-state: load on accept, shift one bit per RUN cycle.
    always_comb begin
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_sh_d   = res_sh_q;
        carry_d    = carry_q;
        c_msb_in_d = c_msb_in_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        co_d       = co_q;
        ovf_d      = ovf_q;

        if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh_d   = bus.A;
            b_sh_d   = bus.SUB ? ~bus.B : bus.B;
            carry_d  = bus.SUB;
            cnt_d    = '0;
            res_sh_d = '0;
        end else if (state_q == SA_RUN) begin
            res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            cnt_d    = cnt_q + 1'b1;

            // Carry leaving bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == CNT_MSB) begin
                c_msb_in_d = fa_cout;
            end

            // Final bit: publish the word so it survives later shifting.
            if (cnt_q == CNT_LAST) begin
                result_d = {fa_sum, res_sh_q[WIDTH-1:1]};
                co_d     = fa_cout;
                ovf_d    = c_msb_in_q ^ fa_cout;
            end
        end
    end

    // Datapath and result registers, all cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            co_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_sh_q   <= res_sh_d;
            carry_q    <= carry_d;
            c_msb_in_q <= c_msb_in_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            co_q       <= co_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.CO     = co_q;
    assign bus.OVF    = ovf_q;
    assign bus.BUSY   = busy;
    assign bus.DONE   = done;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=32.
// Latency: expects DONE on the (WIDTH+1)th sample after the accepting edge.
// Backpressure: drives START only in IDLE/DONE except where ignoring it is the point.
module tb_serial_adder_ctrl;

    localparam int W = 32;

    logic clk;
    logic rst;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int done_twice = 0;
    logic prev_done = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    // DONE must always be a single-cycle pulse.
    always @(negedge clk) begin
        if (bus.DONE && prev_done) done_twice++;
        prev_done = bus.DONE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference: plain two's-complement arithmetic, {ovf, co, result}.
    function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] wide;
        logic [31:0] r;
        logic        co;
        logic        ovf;
        if (!sub) begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[31:0];
            co   = wide[32];
            ovf  = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r    = a - b;
            co   = (a >= b);
            ovf  = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {ovf, co, r};
    endfunction

    // Called at a negedge; the request is taken on the following posedge.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
    endtask

    // Follows one accepted operation to its DONE cycle; returns at that negedge.
    task automatic wait_done(input string name, input logic [31:0] er, input logic eco,
                             input logic eovf, input bit keep_start);
        int busy_bad;
        logic got_done;
        busy_bad = 0;
        got_done = 1'b0;
        @(posedge clk);
        #1;
        if (!keep_start) bus.START = 1'b0;
        // Operands are scrambled after acceptance and must have no effect.
        bus.A   = $urandom;
        bus.B   = $urandom;
        bus.SUB = 1'($urandom_range(0, 1));
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k <= W) begin
                if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) busy_bad++;
            end else begin
                got_done = bus.DONE && !bus.BUSY;
            end
        end
        chk({name, " busy_window_errors"}, 32'(busy_bad), 32'd0);
        chk({name, " done_at_w_plus_1"}, {31'd0, got_done}, 32'd1);
        chk({name, " result"}, bus.RESULT, er);
        chk({name, " co"}, {31'd0, bus.CO}, {31'd0, eco});
        chk({name, " ovf"}, {31'd0, bus.OVF}, {31'd0, eovf});
    endtask

    // After a lone DONE the engine idles and the outputs hold.
    task automatic check_idle_hold(input string name, input logic [31:0] er, input logic eco);
        bus.START = 1'b0;
        @(negedge clk);
        chk({name, " idle_after_done"}, {30'd0, bus.BUSY, bus.DONE}, 32'd0);
        chk({name, " result_held"}, bus.RESULT, er);
        chk({name, " co_held"}, {31'd0, bus.CO}, {31'd0, eco});
    endtask

    initial begin
        logic [33:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        vecs[0] = '{"add_5_3",      32'd5,          32'd3, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",     32'hFFFF_FFFF,  32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{"add_ovf",      32'h7FFF_FFFF,  32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{"sub_3_5",      32'd3,          32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_5_3",      32'd5,          32'd3, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[5] = '{"sub_min_1",    32'h8000_0000,  32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{"sub_0_0",      32'd0,          32'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        bus.START = 1'b0;
        bus.SUB   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {bus.RESULT[29:0], bus.CO, bus.OVF}, 32'd0);
        chk("reset_busy_done", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < 7; i++) begin
            drive_start(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(vecs[i].name, vecs[i].r, vecs[i].co, vecs[i].ovf, 1'b0);
            check_idle_hold(vecs[i].name, vecs[i].r, vecs[i].co);
        end

        // Reset in the middle of a run clears outputs without a clock edge.
        drive_start(32'h11, 32'h22, 1'b0);
        wait_done("pre_reset", 32'h33, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive_start(32'd5, 32'd3, 1'b0);
        @(posedge clk);
        #1 bus.START = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun_reset_busy_done", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
        chk("midrun_reset_result", bus.RESULT, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_start(32'd5, 32'd3, 1'b0);
        wait_done("after_reset", 32'd8, 1'b0, 1'b0, 1'b0);
        check_idle_hold("after_reset", 32'd8, 1'b0);

        // START held through RUN, then a back-to-back request in DONE.
        drive_start(32'h100, 32'h200, 1'b0);
        wait_done("start_held", 32'h300, 1'b0, 1'b0, 1'b1);
        drive_start(32'd1, 32'd1, 1'b0);
        wait_done("back_to_back", 32'd2, 1'b0, 1'b0, 1'b0);
        check_idle_hold("back_to_back", 32'd2, 1'b0);

        // Random operations against the arithmetic model, some chained.
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = 32'h7FFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                default: ;
            endcase
            exp = ref_op(ra, rb, rs);
            drive_start(ra, rb, rs);
            wait_done($sformatf("rand%0d", n), exp[31:0], exp[32], exp[33], 1'b0);
            if ($urandom_range(0, 1) == 0) begin
                bus.START = 1'b0;
                @(negedge clk);
            end
        end

        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_single_pulse", 32'(done_twice), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
